// File: rtl/scan_pkg.sv
// Shared definitions for the scanning line decoder.
// Provides the mode encodings, the active-low one-hot helper and a
// ceiling-log2 helper used to size the dwell prescaler.
package scan_pkg;

    localparam logic MODE_DIRECT = 1'b0;
    localparam logic MODE_SCAN   = 1'b1;

    // Widest address / output vector the helper function supports.
    localparam int unsigned MAX_SEL_W = 8;
    localparam int unsigned MAX_OUT   = 256;

    // Active-low one-hot of idx; all ones when idx is outside 0..n-1.
    function automatic logic [MAX_OUT-1:0] onehot_n(input int unsigned idx,
                                                    input int unsigned n);
        logic [MAX_OUT-1:0] v;
        v = '1;
        if ((idx < n) && (idx < MAX_OUT)) begin
            v[idx[MAX_SEL_W-1:0]] = 1'b0;
        end
        return v;
    endfunction

    // Ceiling log2; returns 0 for v <= 1.
    function automatic int unsigned clog2(input int unsigned v);
        int unsigned r;
        int unsigned x;
        r = 0;
        x = (v > 0) ? v - 1 : 0;
        while (x > 0) begin
            r = r + 1;
            x = x >> 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/scan_prescaler.sv
// Modulo-PRESCALE dwell counter for the scanning decoder.
// Ports:
//   clk, rst  : clock, synchronous active-high reset
//   clr       : force the count to 0 (wins over en)
//   en        : advance the count by one, wrapping after PRESCALE-1
//   count     : registered count value
//   tc        : terminal-count flag, high while count == PRESCALE-1
module scan_prescaler
    import scan_pkg::*;
#(
    parameter int unsigned PRESCALE = 16,
    parameter int unsigned CNT_W    = clog2(PRESCALE)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             en,
    output logic [CNT_W-1:0] count,
    output logic             tc
);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    // Terminal count is a decode of the registered count.
    assign tc    = (count_q == CNT_W'(PRESCALE - 1));
    assign count = count_q;

    // Next-count selection: clear beats advance.
    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = '0;
        end else if (en) begin
            count_d = tc ? '0 : count_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/scan_decoder.sv
// Registered SEL_W-to-NUM_OUT active-low line decoder with auto-scan.
// Direct mode decodes addr; scan mode steps an internal index every
// PRESCALE cycles to drive multiplexed display digit/row selects.
// Optional macro SCAN_BLANK_EN blanks y_n on the last cycle of each dwell.
// Ports:
//   clk, rst            : clock, synchronous active-high reset
//   mode                : 0 = direct decode, 1 = auto-scan
//   addr                : decode address (direct mode)
//   g1, g2a_n, g2b_n    : three-term enable (g1 & ~g2a_n & ~g2b_n)
//   y_n                 : registered active-low one-hot outputs
//   scan_idx            : registered scan index
//   wrap                : one-cycle pulse when scan_idx wraps to 0
module scan_decoder
    import scan_pkg::*;
#(
    parameter int unsigned SEL_W    = 3,
    parameter int unsigned NUM_OUT  = 8,
    parameter int unsigned PRESCALE = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               mode,
    input  logic [SEL_W-1:0]   addr,
    input  logic               g1,
    input  logic               g2a_n,
    input  logic               g2b_n,
    output logic [NUM_OUT-1:0] y_n,
    output logic [SEL_W-1:0]   scan_idx,
    output logic               wrap
);

    localparam int unsigned PRE_W = clog2(PRESCALE);

    logic               en_c;
    logic               entry_c;
    logic               run_c;
    logic               pres_tc;
    logic [PRE_W-1:0]   pres_count;
    logic               unused_count;

    logic               mode_q,  mode_d;
    logic [SEL_W-1:0]   idx_q,   idx_d;
    logic               wrap_q,  wrap_d;
    logic [NUM_OUT-1:0] y_n_q,   y_n_d;

    assign en_c    = g1 & ~g2a_n & ~g2b_n;
    // Scan entry: mode just rose, as seen by the enable-gated mode copy.
    assign entry_c = en_c & (mode == MODE_SCAN) & (mode_q == MODE_DIRECT);
    assign run_c   = en_c & (mode == MODE_SCAN) & ~entry_c;

    scan_prescaler #(
        .PRESCALE (PRESCALE),
        .CNT_W    (PRE_W)
    ) u_prescaler (
        .clk   (clk),
        .rst   (rst),
        .clr   (entry_c),
        .en    (run_c),
        .count (pres_count),
        .tc    (pres_tc)
    );

    // The dwell position itself is only needed through tc.
    assign unused_count = ^pres_count;

    // Next-state and output decode.
    always_comb begin
        mode_d = mode_q;
        idx_d  = idx_q;
        wrap_d = 1'b0;
        y_n_d  = '1;
        if (en_c) begin
            mode_d = mode;
            if (mode == MODE_DIRECT) begin
                y_n_d = NUM_OUT'(onehot_n(32'(addr), NUM_OUT));
            end else begin
                // Output shows the index held during the previous cycle.
                y_n_d = NUM_OUT'(onehot_n(32'(idx_q), NUM_OUT));
`ifdef SCAN_BLANK_EN
                if (pres_tc) begin
                    y_n_d = '1;
                end
`endif
                if (entry_c) begin
                    idx_d = '0;
                end else if (pres_tc) begin
                    if (idx_q == SEL_W'(NUM_OUT - 1)) begin
                        idx_d  = '0;
                        wrap_d = 1'b1;
                    end else begin
                        idx_d = idx_q + SEL_W'(1);
                    end
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mode_q <= MODE_DIRECT;
            idx_q  <= '0;
            wrap_q <= 1'b0;
            y_n_q  <= '1;
        end else begin
            mode_q <= mode_d;
            idx_q  <= idx_d;
            wrap_q <= wrap_d;
            y_n_q  <= y_n_d;
        end
    end

    assign y_n      = y_n_q;
    assign scan_idx = idx_q;
    assign wrap     = wrap_q;

endmodule

// File: tb/tb_scan_decoder.sv
// Self-checking bench for scan_decoder: vector table for direct decode and
// enables, hand sequences for scan wrap / freeze / reset, and a randomized
// run checked against a dwell-time reference model.
module tb_scan_decoder;

    localparam int P  = 4;
    localparam int N0 = 8;
    localparam int N1 = 6;

    logic       clk = 1'b0;
    logic       rst;
    logic       mode;
    logic [2:0] addr;
    logic       g1;
    logic       g2a_n;
    logic       g2b_n;

    logic [7:0] y_a;
    logic [2:0] idx_a;
    logic       wrap_a;
    logic [5:0] y_b;
    logic [2:0] idx_b;
    logic       wrap_b;

    int total = 0;
    int bad   = 0;
    bit chk_en = 1'b0;

    always #5 clk = ~clk;

    scan_decoder #(.SEL_W(3), .NUM_OUT(N0), .PRESCALE(P)) dut_a (
        .clk(clk), .rst(rst), .mode(mode), .addr(addr), .g1(g1),
        .g2a_n(g2a_n), .g2b_n(g2b_n), .y_n(y_a), .scan_idx(idx_a), .wrap(wrap_a)
    );

    scan_decoder #(.SEL_W(3), .NUM_OUT(N1), .PRESCALE(P)) dut_b (
        .clk(clk), .rst(rst), .mode(mode), .addr(addr), .g1(g1),
        .g2a_n(g2a_n), .g2b_n(g2b_n), .y_n(y_b), .scan_idx(idx_b), .wrap(wrap_b)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: phase = enabled scan cycles since scan entry.
    // Index = (phase / P) mod n, dwell position = phase mod P.
    typedef struct {
        int         phase;
        bit         mprev;
        logic [7:0] y;
        bit         wrap;
    } mdl_t;

    mdl_t ma, mb;

    function automatic logic [7:0] oh(input int i, input int n);
        logic [7:0] v;
        v = 8'hFF;
        if (i >= 0 && i < n) v[i] = 1'b0;
        return v;
    endfunction

    function automatic mdl_t mstep(input mdl_t m, input int n, input bit r,
                                   input bit en, input bit md, input int a);
        mdl_t o;
        int   ci;
        o = m;
        ci = (m.phase / P) % n;
        if (r) begin
            o.phase = 0; o.mprev = 1'b0; o.y = 8'hFF; o.wrap = 1'b0;
        end else if (!en) begin
            o.y = 8'hFF; o.wrap = 1'b0;
        end else if (!md) begin
            o.y = oh(a, n); o.wrap = 1'b0; o.mprev = 1'b0;
        end else begin
            o.y = oh(ci, n);
`ifdef SCAN_BLANK_EN
            if ((m.phase % P) == P - 1) o.y = 8'hFF;
`endif
            if (!m.mprev) begin
                o.phase = 0;
                o.wrap  = 1'b0;
            end else begin
                o.phase = m.phase + 1;
                o.wrap  = ((o.phase % (P * n)) == 0);
            end
            o.mprev = 1'b1;
        end
        return o;
    endfunction

    always @(posedge clk) begin
        ma <= mstep(ma, N0, rst, g1 & ~g2a_n & ~g2b_n, mode, int'(addr));
        mb <= mstep(mb, N1, rst, g1 & ~g2a_n & ~g2b_n, mode, int'(addr));
    end

    // Continuous comparison against the model.
    always @(negedge clk) begin
        if (chk_en) begin
            chk("mdl_a_y",    32'(y_a),    32'(ma.y));
            chk("mdl_a_idx",  32'(idx_a),  32'((ma.phase / P) % N0));
            chk("mdl_a_wrap", 32'(wrap_a), 32'(ma.wrap));
            chk("mdl_b_y",    32'(y_b),    32'(mb.y[5:0]));
            chk("mdl_b_idx",  32'(idx_b),  32'((mb.phase / P) % N1));
            chk("mdl_b_wrap", 32'(wrap_b), 32'(mb.wrap));
        end
    end

    typedef struct {
        logic       g1;
        logic       g2a_n;
        logic       g2b_n;
        logic [2:0] addr;
        logic [7:0] exp_y;
    } vec_t;

    vec_t tv[12];

    initial begin
        logic [7:0] ey;
        int r;

        tv[0]  = '{1'b1, 1'b0, 1'b0, 3'd0, 8'hFE};
        tv[1]  = '{1'b1, 1'b0, 1'b0, 3'd1, 8'hFD};
        tv[2]  = '{1'b1, 1'b0, 1'b0, 3'd2, 8'hFB};
        tv[3]  = '{1'b1, 1'b0, 1'b0, 3'd3, 8'hF7};
        tv[4]  = '{1'b1, 1'b0, 1'b0, 3'd4, 8'hEF};
        tv[5]  = '{1'b1, 1'b0, 1'b0, 3'd5, 8'hDF};
        tv[6]  = '{1'b1, 1'b0, 1'b0, 3'd6, 8'hBF};
        tv[7]  = '{1'b1, 1'b0, 1'b0, 3'd7, 8'h7F};
        tv[8]  = '{1'b0, 1'b0, 1'b0, 3'd3, 8'hFF};
        tv[9]  = '{1'b1, 1'b1, 1'b0, 3'd3, 8'hFF};
        tv[10] = '{1'b1, 1'b0, 1'b1, 3'd3, 8'hFF};
        tv[11] = '{1'b1, 1'b0, 1'b0, 3'd3, 8'hF7};

        rst = 1'b1; mode = 1'b0; addr = 3'd0; g1 = 1'b0; g2a_n = 1'b1; g2b_n = 1'b1;
        repeat (2) @(negedge clk);
        chk("rst_y",    32'(y_a),    32'hFF);
        chk("rst_idx",  32'(idx_a),  32'd0);
        chk("rst_wrap", 32'(wrap_a), 32'd0);
        rst = 1'b0;
        chk_en = 1'b1;

        // Direct sweep and enable cases.
        for (int i = 0; i < 12; i++) begin
            g1 = tv[i].g1; g2a_n = tv[i].g2a_n; g2b_n = tv[i].g2b_n; addr = tv[i].addr;
            for (int c = 0; c < 5; c++) begin
                @(negedge clk);
                chk($sformatf("vec%0d_c%0d", i, c), 32'(y_a), 32'(tv[i].exp_y));
            end
        end

        // Scan entry and wrap periods for NUM_OUT = 8 and 6.
        mode = 1'b1;
        @(negedge clk);
        for (int k = 1; k <= 48; k++) begin
            @(negedge clk);
            chk($sformatf("scan_a_idx_k%0d", k),  32'(idx_a),  32'((k / 4) % 8));
            chk($sformatf("scan_a_wrap_k%0d", k), 32'(wrap_a), 32'(k == 32));
            chk($sformatf("scan_b_idx_k%0d", k),  32'(idx_b),  32'((k / 4) % 6));
            chk($sformatf("scan_b_wrap_k%0d", k), 32'(wrap_b), 32'(k == 24 || k == 48));
            if (k <= 4) begin
                ey = 8'hFE;
`ifdef SCAN_BLANK_EN
                if (k == 4) ey = 8'hFF;
`endif
                chk($sformatf("scan_a_y_k%0d", k), 32'(y_a), 32'(ey));
            end
        end

        // Reach index 5, dwell position 2, then freeze.
        repeat (6) @(negedge clk);
        chk("frz_pre_idx", 32'(idx_a), 32'd5);
        g2a_n = 1'b1;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            chk($sformatf("frz_y_c%0d", c),   32'(y_a),   32'hFF);
            chk($sformatf("frz_idx_c%0d", c), 32'(idx_a), 32'd5);
        end
        g2a_n = 1'b0;
        @(negedge clk);
        chk("rel1_idx", 32'(idx_a), 32'd5);
        chk("rel1_y",   32'(y_a),   32'hDF);
        @(negedge clk);
        chk("rel2_idx", 32'(idx_a), 32'd6);

        // Reset mid-scan, then scanning restarts at index 0.
        rst = 1'b1;
        @(negedge clk);
        chk("mrst_y",    32'(y_a),    32'hFF);
        chk("mrst_idx",  32'(idx_a),  32'd0);
        chk("mrst_wrap", 32'(wrap_a), 32'd0);
        rst = 1'b0;
        repeat (4) @(negedge clk);
        chk("resume_idx0", 32'(idx_a), 32'd0);
        @(negedge clk);
        chk("resume_idx1", 32'(idx_a), 32'd1);

        // Randomized run against the model.
        for (int c = 0; c < 1500; c++) begin
            r = int'($urandom_range(0, 199));
            rst = (r == 0);
            if (r >= 1 && r <= 4) mode = ~mode;
            g1    = ($urandom_range(0, 19) != 0);
            g2a_n = ($urandom_range(0, 19) == 0);
            g2b_n = ($urandom_range(0, 19) == 0);
            addr  = 3'($urandom);
            @(negedge clk);
        end

        chk_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/scan_decoder.md
Name: scan_decoder

Overview:
- Parametrised, registered successor to the 3-to-8 line decoder: SEL_W-bit address to NUM_OUT active-low one-hot outputs, with the same three-term enable (g1 & ~g2a_n & ~g2b_n).
- Adds an auto-scan mode. An internal prescaler and index counter cycle the selected output, so the block drives digit/row select for multiplexed 7-segment and LED-matrix displays without external address logic.

Parameters:
- SEL_W, 3, address width.
- NUM_OUT, 8, number of outputs; legal range 2 to 2**SEL_W.
- PRESCALE, 16, clock cycles each index dwells in scan mode; minimum 2.

Ports:
- clk  in  1  system clock; all state updates on its rising edge.
- rst  in  1  synchronous, active-high reset.
- mode  in  1  0 = direct decode of addr; 1 = auto-scan.
- addr  in  SEL_W  decode address; used in direct mode only.
- g1  in  1  active-high enable.
- g2a_n  in  1  active-low enable.
- g2b_n  in  1  active-low enable.
- y_n  out  NUM_OUT  active-low one-hot outputs; registered.
- scan_idx  out  SEL_W  current scan index; registered.
- wrap  out  1  one-cycle pulse when scan_idx wraps from NUM_OUT-1 to 0.

Behaviour:
- Reset
  - rst high at a clock edge: y_n = all ones, scan_idx = 0, prescaler = 0, wrap = 0.
  - Reset takes priority over every other input, including a scan in progress.
- Enable: en = g1 & ~g2a_n & ~g2b_n.
  - en = 0: y_n <= all ones, wrap <= 0.
  - en = 0: prescaler and scan_idx hold their values (frozen, not cleared).
- Direct mode (mode = 0, en = 1)
  - y_n <= ~(1 << addr), one-cycle latency.
  - addr >= NUM_OUT: y_n <= all ones.
  - Prescaler and scan_idx hold.
- Scan mode (mode = 1, en = 1)
  - Prescaler counts 0 .. PRESCALE-1 and wraps to 0.
  - When the prescaler = PRESCALE-1, scan_idx advances by 1 on that edge.
  - scan_idx = NUM_OUT-1 wraps to 0; wrap = 1 for exactly that following cycle.
  - y_n <= ~(1 << scan_idx), lagging scan_idx by one cycle. Each index is therefore shown on y_n for exactly PRESCALE consecutive cycles.
- Mode entry
  - When mode was 0 last cycle and is 1 now (edge detected with a registered copy of mode), prescaler and scan_idx clear to 0 on that edge.
  - Mode register resets to 0.
- Simultaneous events
  - Mode-entry clear beats prescaler advance.
  - en = 0 beats mode-entry clear: the clear is deferred to the first enabled cycle while mode = 1, because the edge register only updates when en = 1.
- Mode exit (1 to 0): takes effect on the next edge; scan state holds.
- Arithmetic
  - Prescaler width is clog2(PRESCALE).
  - scan_idx compares against NUM_OUT-1, not 2**SEL_W-1, so non-power-of-two NUM_OUT wraps correctly.

Optional Feature:
- Macro: SCAN_BLANK_EN.
- Defined
  - In scan mode, y_n is forced to all ones for the last cycle of every dwell (registered prescaler = PRESCALE-1). This gives a ghosting-suppression gap.
  - Visible active time per index is PRESCALE-1 cycles.
  - scan_idx and wrap timing are unchanged.
- Not defined
  - No blanking; each index is active for all PRESCALE cycles.
- Direct mode is identical in both cases.

Decomposition:
- Shared package scan_pkg
  - Mode constants MODE_DIRECT = 0 and MODE_SCAN = 1.
  - Function onehot_n(idx, n): returns the active-low one-hot vector, or all ones when idx >= n.
  - Function clog2 for prescaler sizing.
- Sub-module scan_prescaler: parametrised modulo-PRESCALE counter.
  - Inputs: clk, rst, clr, en.
  - Outputs: count and a terminal-count strobe tc.
  - The top level instantiates it once and owns scan_idx, wrap and y_n.

Test Plan (PRESCALE = 4, SEL_W = 3, NUM_OUT = 8 unless stated):
- Direct sweep: en = 1, mode = 0, addr 0..7, 5 cycles each -> y_n one cycle later = 8'hFE, FD, FB, F7, EF, DF, BF, 7F.
- Disable cases: g1 = 0, or g2a_n = 1, or g2b_n = 1, each with addr = 3 -> y_n = 8'hFF; restoring en gives 8'hF7 after one cycle.
- Scan wrap: mode 0 -> 1 with en = 1.
  - scan_idx steps 0..7, 4 cycles each.
  - wrap high for one cycle when scan_idx returns to 0, 32 cycles after entry.
  - y_n = 8'hFE for cycles 1-4 after entry.
  - Repeat with NUM_OUT = 6 -> wrap after scan_idx = 5, every 24 cycles.
- Freeze: scan_idx = 5, prescaler = 2; g2a_n = 1 for 10 cycles.
  - During: y_n = 8'hFF, scan_idx stays 5.
  - On release: two more cycles at index 5, then advance to 6.
- Reset mid-scan: rst = 1 for 1 cycle while scan_idx = 6 -> next cycle y_n = 8'hFF, scan_idx = 0, wrap = 0; scanning resumes from index 0 after reset.
- SCAN_BLANK_EN defined: scan mode -> each index shows its one-hot pattern for 3 cycles, then 8'hFF for 1 cycle; wrap period still 32 cycles.
